pfmem_arbiter: RTL and testbench
================================

PFMEM_ARBITER -- requirements
Module: pfmem_arbiter

Interface
REQ-001 Parameter AW, default 30: Wishbone word-address width.
REQ-002 Parameter DW, default 32: Wishbone data width.
REQ-003 Parameter STARVE_LIMIT, default 16: count of prefetch wait cycles under a data grant that forces a prefetch-priority grant. Legal range 1..255.
REQ-004 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_reset_n  in  1  synchronous, active-low reset.
REQ-006 i_d_cyc, i_d_stb, i_d_we  in  1 each  data (memory-unit) master request.
REQ-007 i_d_addr  in  AW, i_d_data  in  DW, i_d_sel  in  DW/8  data master address, write data and byte selects.
REQ-008 o_d_stall, o_d_ack, o_d_err  out  1 each; o_d_data  out  DW  data master response.
REQ-009 i_p_cyc, i_p_stb  in  1 each; i_p_addr  in  AW  prefetch master request (read-only).
REQ-010 o_p_stall, o_p_ack, o_p_err  out  1 each; o_p_data  out  DW  prefetch master response.
REQ-011 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each; o_wb_addr  out  AW; o_wb_data  out  DW; o_wb_sel  out  DW/8  shared bus request.
REQ-012 i_wb_stall, i_wb_ack, i_wb_err  in  1 each; i_wb_data  in  DW  shared bus response.
REQ-013 o_grant  out  2  current owner: 2'b00 idle, 2'b01 data, 2'b10 prefetch.

Function
REQ-014 Owner state SHALL be one registered FSM: IDLE, GNT_D, GNT_P.
REQ-015 State transition on every edge: if the current owner's cyc is high, state holds; otherwise state becomes GNT_D if i_d_cyc and not favor_p, else GNT_P if i_p_cyc, else GNT_D if i_d_cyc, else IDLE.
REQ-016 Bus outputs SHALL be combinational muxes of the owner's signals: cyc, stb, we, addr, data, sel. In IDLE, o_wb_cyc=o_wb_stb=0.
REQ-017 For prefetch ownership: o_wb_we=0, o_wb_sel=all ones, o_wb_data=0.
REQ-018 The owner SHALL see stall=i_wb_stall. A non-owner SHALL see stall=1.
REQ-019 i_wb_ack and i_wb_err SHALL route only to the owner, gated by o_wb_cyc. The non-owner SHALL see ack=err=0. Responses arriving while o_wb_cyc=0 SHALL be dropped.
REQ-020 o_d_data and o_p_data SHALL both equal i_wb_data. They are meaningful only with the matching ack.
REQ-021 An owner deasserting cyc, including a prefetch abort on a new PC, SHALL drop o_wb_cyc in that same cycle. A newly granted owner's cyc appears no earlier than the next cycle, so there is at least one idle bus cycle between owners.
REQ-022 Arbitration latency: a request arriving while the bus is IDLE reaches o_wb_cyc exactly 1 cycle after i_*_cyc rises.
REQ-023 Starvation counter (8 bits): increments each cycle with state==GNT_D and i_p_cyc=1, saturating at STARVE_LIMIT.
REQ-024 The starvation counter clears when state==GNT_P or i_p_cyc=0.
REQ-025 favor_p SHALL be 1 while the starvation counter equals STARVE_LIMIT.
REQ-026 Simultaneous first requests from IDLE (both cyc rising together, favor_p=0): data wins.
REQ-027 An ack and the owner dropping cyc in the same cycle SHALL deliver the ack, then rearbitrate at that edge.
REQ-028 Outputs SHALL never present a request to the bus for a master whose cyc is low.

Reset
REQ-029 With i_reset_n=0 at an edge: state=IDLE, starvation counter=0, favor_p=0.
REQ-030 During and after reset, until the next grant: o_grant=0, o_wb_cyc=o_wb_stb=0, o_d_ack=o_p_ack=o_d_err=o_p_err=0, o_d_stall=o_p_stall=1.
REQ-031 Reset mid-transaction SHALL abandon ownership immediately, with no ack forwarded after the reset edge.

Structure
REQ-032 A shared package SHALL hold the owner state encoding (IDLE/GNT_D/GNT_P, matching o_grant) and the default STARVE_LIMIT.
REQ-033 The block SHALL be a single module. The starvation counter MAY be a sub-module named starve_counter; no other sub-modules.

Verification
REQ-034 Prefetch alone: i_p_cyc=i_p_stb=1, i_p_addr=0x100 -> o_wb_cyc=1, o_wb_addr=0x100, o_wb_we=0 one cycle later; bus ack with data 0xDEADBEEF -> o_p_ack=1, o_p_data=0xDEADBEEF, o_d_ack=0.
REQ-035 Simultaneous requests from IDLE -> o_grant=01 and o_p_stall=1; data drops cyc after its ack -> idle bus cycle, then o_grant=10 with prefetch address on the bus.
REQ-036 Data master holds cyc across back-to-back transactions while prefetch waits 16 cycles -> after data drops cyc, prefetch is granted even though i_d_cyc is reasserted in that cycle.
REQ-037 Prefetch owner drops cyc mid-transaction (abort) -> o_wb_cyc=0 in the same cycle; a late i_wb_ack the next cycle produces no o_p_ack or o_d_ack.
REQ-038 Bus error during a data write with i_d_sel=4'b0011 -> o_wb_sel=4'b0011 while granted; o_d_err=1 for one cycle; o_p_err=0.
REQ-039 i_reset_n=0 asserted during GNT_D -> o_grant=00 and o_wb_cyc=0 after the edge; the counter reads 0.

Source files
------------

// File: rtl/pfmem_arbiter_pkg.sv
// pfmem_arbiter_pkg
// Shared definitions for the prefetch/memory Wishbone arbiter.
//   owner_e       : bus owner state; the encoding is driven straight onto o_grant
//   STARVE_LIMIT_DEFAULT : default prefetch wait count that forces a prefetch grant
//   STARVE_CNT_W  : width of the starvation counter
package pfmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_D = 2'b01,
        GNT_P = 2'b10
    } owner_e;

    localparam int STARVE_LIMIT_DEFAULT = 16;
    localparam int STARVE_CNT_W         = 8;

endpackage

// File: rtl/pfmem_arbiter_if.sv
// pfmem_arbiter_if
// Bundles the three Wishbone sides seen by the arbiter:
//   data master     : i_d_* requests, o_d_* responses
//   prefetch master : i_p_* requests (read-only), o_p_* responses
//   shared bus      : o_wb_* requests, i_wb_* responses
//   o_grant         : current owner (00 idle, 01 data, 10 prefetch)
// Modport slave is the arbiter's view; master is the view of whatever drives
// the two masters and models the shared bus slave.
interface pfmem_arbiter_if #(
    parameter int AW = 30,
    parameter int DW = 32
);
    logic            i_d_cyc, i_d_stb, i_d_we;
    logic [AW-1:0]   i_d_addr;
    logic [DW-1:0]   i_d_data;
    logic [DW/8-1:0] i_d_sel;
    logic            o_d_stall, o_d_ack, o_d_err;
    logic [DW-1:0]   o_d_data;

    logic            i_p_cyc, i_p_stb;
    logic [AW-1:0]   i_p_addr;
    logic            o_p_stall, o_p_ack, o_p_err;
    logic [DW-1:0]   o_p_data;

    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW-1:0]   o_wb_data;
    logic [DW/8-1:0] o_wb_sel;
    logic            i_wb_stall, i_wb_ack, i_wb_err;
    logic [DW-1:0]   i_wb_data;

    logic [1:0]      o_grant;

    modport slave (
        input  i_d_cyc, i_d_stb, i_d_we, i_d_addr, i_d_data, i_d_sel,
        output o_d_stall, o_d_ack, o_d_err, o_d_data,
        input  i_p_cyc, i_p_stb, i_p_addr,
        output o_p_stall, o_p_ack, o_p_err, o_p_data,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        output o_grant
    );

    modport master (
        output i_d_cyc, i_d_stb, i_d_we, i_d_addr, i_d_data, i_d_sel,
        input  o_d_stall, o_d_ack, o_d_err, o_d_data,
        output i_p_cyc, i_p_stb, i_p_addr,
        input  o_p_stall, o_p_ack, o_p_err, o_p_data,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        input  o_grant
    );
endinterface

// File: rtl/pfmem_arbiter_starve_counter.sv
// starve_counter
// Counts cycles the prefetch master spends waiting behind a data grant.
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_inc            : data owns the bus while prefetch requests
//   i_clr            : prefetch owns the bus or is not requesting (wins over i_inc)
//   o_count          : current count, saturates at LIMIT
module starve_counter
    import pfmem_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_inc,
    input  logic                    i_clr,
    output logic [STARVE_CNT_W-1:0] o_count
);

    localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr)
            cnt_d = '0;
        else if (i_inc && cnt_q != LIM)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign o_count = cnt_q;

endmodule

// File: rtl/pfmem_arbiter.sv
// pfmem_arbiter
// Two-master Wishbone arbiter: a data (memory-unit) master and a read-only
// prefetch master share one bus. Ownership is a registered FSM; all bus and
// response routing is combinational from the owner, so an owner dropping cyc
// frees the bus in that same cycle and a new owner appears one cycle later.
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   bus              : pfmem_arbiter_if.slave (data, prefetch, shared bus, o_grant)
module pfmem_arbiter
    import pfmem_arbiter_pkg::*;
#(
    parameter int AW           = 30,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    pfmem_arbiter_if.slave  bus
);

    localparam logic [AW-1:0]   ADDR_ZERO = '0;
    localparam logic [DW-1:0]   DATA_ZERO = '0;
    localparam logic [DW/8-1:0] SEL_NONE  = '0;
    localparam logic [DW/8-1:0] SEL_ALL   = '1;
    localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(STARVE_LIMIT);

    owner_e state_q, state_d;
    owner_e own;          // owner as seen by the outputs
    logic   owner_cyc;    // registered owner's cyc (for state hold)
    logic   bus_cyc;
    logic   favor_p;
    logic [STARVE_CNT_W-1:0] starve_cnt;

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (state_q == GNT_D && bus.i_p_cyc),
        .i_clr     (state_q == GNT_P || !bus.i_p_cyc),
        .o_count   (starve_cnt)
    );

    assign favor_p = (starve_cnt == LIM);

    // Next owner: hold while the owner keeps cyc, otherwise rearbitrate.
    always_comb begin
        state_d   = state_q;
        owner_cyc = 1'b0;
        case (state_q)
            GNT_D:   owner_cyc = bus.i_d_cyc;
            GNT_P:   owner_cyc = bus.i_p_cyc;
            default: owner_cyc = 1'b0;
        endcase
        if (!owner_cyc) begin
            if (bus.i_d_cyc && !favor_p)
                state_d = GNT_D;
            else if (bus.i_p_cyc)
                state_d = GNT_P;
            else if (bus.i_d_cyc)
                state_d = GNT_D;
            else
                state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // While reset is held the outputs already look idle, so nothing leaks
    // from a grant that the reset edge is about to abandon.
    assign own = i_reset_n ? state_q : IDLE;

    always_comb begin
        bus_cyc        = 1'b0;
        bus.o_wb_stb   = 1'b0;
        bus.o_wb_we    = 1'b0;
        bus.o_wb_addr  = ADDR_ZERO;
        bus.o_wb_data  = DATA_ZERO;
        bus.o_wb_sel   = SEL_NONE;
        bus.o_d_stall  = 1'b1;
        bus.o_p_stall  = 1'b1;
        case (own)
            GNT_D: begin
                bus_cyc       = bus.i_d_cyc;
                bus.o_wb_stb  = bus.i_d_cyc & bus.i_d_stb;
                bus.o_wb_we   = bus.i_d_we;
                bus.o_wb_addr = bus.i_d_addr;
                bus.o_wb_data = bus.i_d_data;
                bus.o_wb_sel  = bus.i_d_sel;
                bus.o_d_stall = bus.i_wb_stall;
            end
            GNT_P: begin
                bus_cyc       = bus.i_p_cyc;
                bus.o_wb_stb  = bus.i_p_cyc & bus.i_p_stb;
                bus.o_wb_addr = bus.i_p_addr;
                bus.o_wb_sel  = SEL_ALL;
                bus.o_p_stall = bus.i_wb_stall;
            end
            default: ;
        endcase
    end

    // Responses only reach the owner and only while its cycle is open;
    // late acks after an abort fall on the floor.
    assign bus.o_wb_cyc = bus_cyc;
    assign bus.o_d_ack  = (own == GNT_D) && bus_cyc && bus.i_wb_ack;
    assign bus.o_d_err  = (own == GNT_D) && bus_cyc && bus.i_wb_err;
    assign bus.o_p_ack  = (own == GNT_P) && bus_cyc && bus.i_wb_ack;
    assign bus.o_p_err  = (own == GNT_P) && bus_cyc && bus.i_wb_err;
    assign bus.o_d_data = bus.i_wb_data;
    assign bus.o_p_data = bus.i_wb_data;
    assign bus.o_grant  = own;

endmodule

// File: tb/tb_pfmem_arbiter.sv
module tb_pfmem_arbiter;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int LIMIT = 16;

    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    pfmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    pfmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: owner 0 none, 1 data, 2 prefetch; wait counter.
    int m_own = 0;
    int m_cnt = 0;

    function automatic bit m_owner_keeps();
        return (m_own == 1 && bus.i_d_cyc === 1'b1) || (m_own == 2 && bus.i_p_cyc === 1'b1);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_own <= 0;
            m_cnt <= 0;
        end else begin
            if (m_own == 2 || !bus.i_p_cyc) m_cnt <= 0;
            else if (m_own == 1 && m_cnt < LIMIT) m_cnt <= m_cnt + 1;
            if (!m_owner_keeps()) begin
                if (bus.i_d_cyc && m_cnt != LIMIT) m_own <= 1;
                else if (bus.i_p_cyc) m_own <= 2;
                else if (bus.i_d_cyc) m_own <= 1;
                else m_own <= 0;
            end
        end
    end

    function automatic logic [76:0] exp_vec();
        int g;
        logic c, s, w, ds, dk, de, ps, pk, pe;
        logic [AW-1:0] a;
        logic [DW-1:0] dt;
        logic [3:0] sl;
        g  = rst_n ? m_own : 0;
        c  = (g == 1) ? bus.i_d_cyc : (g == 2) ? bus.i_p_cyc : 1'b0;
        s  = c && ((g == 1) ? bus.i_d_stb : bus.i_p_stb);
        w  = (g == 1) ? bus.i_d_we : 1'b0;
        a  = (g == 1) ? bus.i_d_addr : (g == 2) ? bus.i_p_addr : '0;
        dt = (g == 1) ? bus.i_d_data : '0;
        sl = (g == 1) ? bus.i_d_sel : (g == 2) ? 4'hF : 4'h0;
        ds = (g == 1) ? bus.i_wb_stall : 1'b1;
        ps = (g == 2) ? bus.i_wb_stall : 1'b1;
        dk = (g == 1) && c && bus.i_wb_ack;
        de = (g == 1) && c && bus.i_wb_err;
        pk = (g == 2) && c && bus.i_wb_ack;
        pe = (g == 2) && c && bus.i_wb_err;
        return {2'(g), c, s, w, a, dt, sl, ds, dk, de, ps, pk, pe};
    endfunction

    function automatic logic [76:0] act_vec();
        return {bus.o_grant, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_addr,
                bus.o_wb_data, bus.o_wb_sel, bus.o_d_stall, bus.o_d_ack, bus.o_d_err,
                bus.o_p_stall, bus.o_p_ack, bus.o_p_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.i_d_cyc = 0; bus.i_d_stb = 0; bus.i_d_we = 0;
        bus.i_d_addr = '0; bus.i_d_data = '0; bus.i_d_sel = '0;
        bus.i_p_cyc = 0; bus.i_p_stb = 0; bus.i_p_addr = '0;
        bus.i_wb_stall = 0; bus.i_wb_ack = 0; bus.i_wb_err = 0; bus.i_wb_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clr_inputs();
        bus.i_d_cyc = 1; bus.i_d_stb = 1; bus.i_wb_ack = 1;
        tick(); tick();
        @(negedge clk);
        n_chk++; if (bus.o_grant !== 2'b00) begin n_err++; $display("FAIL rst_grant got=%0h exp=0", bus.o_grant); end
        n_chk++; if ({bus.o_wb_cyc, bus.o_wb_stb} !== 2'b00) begin n_err++; $display("FAIL rst_cyc_stb got=%0b%0b exp=00", bus.o_wb_cyc, bus.o_wb_stb); end
        n_chk++; if ({bus.o_d_stall, bus.o_p_stall, bus.o_d_ack, bus.o_p_ack, bus.o_d_err, bus.o_p_err} !== 6'b110000) begin
            n_err++; $display("FAIL rst_resp got=%b exp=110000", {bus.o_d_stall, bus.o_p_stall, bus.o_d_ack, bus.o_p_ack, bus.o_d_err, bus.o_p_err}); end
        n_chk++; if (dut.starve_cnt !== 8'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", dut.starve_cnt); end
        tick();
        clr_inputs();
        rst_n = 1;
        tick();
        @(negedge clk);
        n_chk++; if ({bus.o_grant, bus.o_wb_cyc, bus.o_d_stall, bus.o_p_stall} !== 5'b00011) begin
            n_err++; $display("FAIL post_rst_idle got=%b exp=00011", {bus.o_grant, bus.o_wb_cyc, bus.o_d_stall, bus.o_p_stall}); end
    endtask

    task automatic test_prefetch_alone();
        tick();
        bus.i_p_cyc = 1; bus.i_p_stb = 1; bus.i_p_addr = 30'h100;
        @(negedge clk);
        n_chk++; if (bus.o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL pf_latency0 got=%0b exp=0", bus.o_wb_cyc); end
        tick();
        @(negedge clk);
        n_chk++; if ({bus.o_wb_cyc, bus.o_wb_we, bus.o_grant} !== 4'b1010) begin
            n_err++; $display("FAIL pf_grant got=%b exp=1010", {bus.o_wb_cyc, bus.o_wb_we, bus.o_grant}); end
        n_chk++; if (bus.o_wb_addr !== 30'h100 || bus.o_wb_sel !== 4'hF || bus.o_wb_data !== 32'h0) begin
            n_err++; $display("FAIL pf_bus got=%h/%h/%h exp=100/f/0", bus.o_wb_addr, bus.o_wb_sel, bus.o_wb_data); end
        tick();
        bus.i_wb_ack = 1; bus.i_wb_data = 32'hDEADBEEF;
        @(negedge clk);
        n_chk++; if ({bus.o_p_ack, bus.o_d_ack} !== 2'b10 || bus.o_p_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL pf_ack got=%b/%h exp=10/deadbeef", {bus.o_p_ack, bus.o_d_ack}, bus.o_p_data); end
        tick();
        clr_inputs();
        @(negedge clk);
        n_chk++; if (bus.o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL pf_release got=%0b exp=0", bus.o_wb_cyc); end
        tick();
    endtask

    task automatic test_simultaneous();
        bus.i_d_cyc = 1; bus.i_d_stb = 1; bus.i_d_addr = 30'h200;
        bus.i_p_cyc = 1; bus.i_p_stb = 1; bus.i_p_addr = 30'h300;
        tick();
        @(negedge clk);
        n_chk++; if ({bus.o_grant, bus.o_p_stall} !== 3'b011 || bus.o_wb_addr !== 30'h200) begin
            n_err++; $display("FAIL sim_data_wins got=%b/%h exp=011/200", {bus.o_grant, bus.o_p_stall}, bus.o_wb_addr); end
        bus.i_wb_ack = 1;
        #1;
        n_chk++; if ({bus.o_d_ack, bus.o_p_ack} !== 2'b10) begin n_err++; $display("FAIL sim_dack got=%b exp=10", {bus.o_d_ack, bus.o_p_ack}); end
        tick();
        bus.i_wb_ack = 0; bus.i_d_cyc = 0; bus.i_d_stb = 0;
        @(negedge clk);
        n_chk++; if (bus.o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL sim_idle_gap got=%0b exp=0", bus.o_wb_cyc); end
        tick();
        @(negedge clk);
        n_chk++; if (bus.o_grant !== 2'b10 || bus.o_wb_cyc !== 1'b1 || bus.o_wb_addr !== 30'h300) begin
            n_err++; $display("FAIL sim_pf_next got=%h/%b/%h exp=2/1/300", bus.o_grant, bus.o_wb_cyc, bus.o_wb_addr); end
        clr_inputs();
        tick();
    endtask

    task automatic test_starve();
        bus.i_d_cyc = 1; bus.i_d_stb = 1; bus.i_d_addr = 30'h10;
        bus.i_p_cyc = 1; bus.i_p_stb = 1; bus.i_p_addr = 30'h500;
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.i_wb_ack = i[0];
            bus.i_d_addr = 30'(i);
            tick();
        end
        bus.i_wb_ack = 0;
        @(negedge clk);
        n_chk++; if (dut.starve_cnt !== 8'(LIMIT)) begin n_err++; $display("FAIL starve_sat got=%0d exp=%0d", dut.starve_cnt, LIMIT); end
        n_chk++; if (bus.o_grant !== 2'b01) begin n_err++; $display("FAIL starve_hold got=%0h exp=1", bus.o_grant); end
        tick();
        bus.i_d_cyc = 0; bus.i_d_stb = 0;
        tick();
        bus.i_d_cyc = 1; bus.i_d_stb = 1;
        @(negedge clk);
        n_chk++; if (bus.o_grant !== 2'b10 || bus.o_wb_addr !== 30'h500 || bus.o_d_stall !== 1'b1) begin
            n_err++; $display("FAIL starve_pf_grant got=%h/%h/%b exp=2/500/1", bus.o_grant, bus.o_wb_addr, bus.o_d_stall); end
        tick();
        @(negedge clk);
        n_chk++; if (dut.starve_cnt !== 8'd0) begin n_err++; $display("FAIL starve_clear got=%0d exp=0", dut.starve_cnt); end
        bus.i_p_cyc = 0; bus.i_p_stb = 0;
        tick();
        clr_inputs();
        tick(); tick();
    endtask

    task automatic test_abort();
        bus.i_p_cyc = 1; bus.i_p_stb = 1; bus.i_p_addr = 30'h700;
        tick();
        @(negedge clk);
        n_chk++; if (bus.o_wb_cyc !== 1'b1) begin n_err++; $display("FAIL abort_pre got=%0b exp=1", bus.o_wb_cyc); end
        tick();
        bus.i_p_cyc = 0; bus.i_p_stb = 0;
        @(negedge clk);
        n_chk++; if ({bus.o_wb_cyc, bus.o_wb_stb} !== 2'b00) begin n_err++; $display("FAIL abort_drop got=%b exp=00", {bus.o_wb_cyc, bus.o_wb_stb}); end
        tick();
        bus.i_wb_ack = 1;
        @(negedge clk);
        n_chk++; if ({bus.o_p_ack, bus.o_d_ack, bus.o_grant} !== 4'b0000) begin
            n_err++; $display("FAIL abort_late_ack got=%b exp=0000", {bus.o_p_ack, bus.o_d_ack, bus.o_grant}); end
        tick();
        clr_inputs();
    endtask

    task automatic test_err();
        bus.i_d_cyc = 1; bus.i_d_stb = 1; bus.i_d_we = 1; bus.i_d_sel = 4'b0011;
        bus.i_d_addr = 30'h44; bus.i_d_data = 32'h12345678;
        tick();
        @(negedge clk);
        n_chk++; if (bus.o_wb_sel !== 4'b0011 || bus.o_wb_we !== 1'b1 || bus.o_wb_data !== 32'h12345678) begin
            n_err++; $display("FAIL err_write got=%b/%b/%h exp=0011/1/12345678", bus.o_wb_sel, bus.o_wb_we, bus.o_wb_data); end
        tick();
        bus.i_wb_err = 1;
        @(negedge clk);
        n_chk++; if ({bus.o_d_err, bus.o_p_err, bus.o_d_ack} !== 3'b100) begin
            n_err++; $display("FAIL err_route got=%b exp=100", {bus.o_d_err, bus.o_p_err, bus.o_d_ack}); end
        tick();
        bus.i_wb_err = 0;
        @(negedge clk);
        n_chk++; if (bus.o_d_err !== 1'b0) begin n_err++; $display("FAIL err_one_cycle got=%0b exp=0", bus.o_d_err); end
        clr_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.i_d_cyc = 1; bus.i_d_stb = 1; bus.i_p_cyc = 1; bus.i_p_stb = 1;
        tick(); tick(); tick();
        @(negedge clk);
        n_chk++; if (bus.o_grant !== 2'b01 || dut.starve_cnt === 8'd0) begin
            n_err++; $display("FAIL rmid_pre got=%h/%0d exp=1/nonzero", bus.o_grant, dut.starve_cnt); end
        bus.i_wb_ack = 1;
        rst_n = 0;
        tick();
        @(negedge clk);
        n_chk++; if ({bus.o_grant, bus.o_wb_cyc, bus.o_d_ack} !== 4'b0000 || dut.starve_cnt !== 8'd0) begin
            n_err++; $display("FAIL rmid_after got=%b/%0d exp=0000/0", {bus.o_grant, bus.o_wb_cyc, bus.o_d_ack}, dut.starve_cnt); end
        clr_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) bus.i_d_cyc = ~bus.i_d_cyc;
            if ($urandom_range(5) == 0) bus.i_p_cyc = ~bus.i_p_cyc;
            bus.i_d_stb = 1'($urandom);
            bus.i_p_stb = 1'($urandom);
            bus.i_d_we = 1'($urandom);
            bus.i_d_addr = 30'($urandom);
            bus.i_p_addr = 30'($urandom);
            bus.i_d_data = $urandom;
            bus.i_d_sel = 4'($urandom);
            bus.i_wb_stall = 1'($urandom);
            bus.i_wb_ack = ($urandom_range(2) == 0);
            bus.i_wb_err = ($urandom_range(9) == 0);
            bus.i_wb_data = $urandom;
            rst_n = ($urandom_range(49) != 0);
            @(negedge clk);
            n_chk++; if (act_vec() !== exp_vec()) begin n_err++; $display("FAIL rnd_outputs cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec()); end
            n_chk++; if (dut.starve_cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, dut.starve_cnt, m_cnt); end
            n_chk++; if (bus.o_d_data !== bus.i_wb_data || bus.o_p_data !== bus.i_wb_data) begin
                n_err++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h", i, bus.o_d_data, bus.o_p_data, bus.i_wb_data); end
            tick();
        end
        clr_inputs();
        rst_n = 1;
        tick();
    endtask

    initial begin
        rst_n = 0;
        clr_inputs();
        test_reset();
        test_prefetch_alone();
        test_simultaneous();
        test_starve();
        test_abort();
        test_err();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
